gpio_sched: RTL

- Parametrised successor to the single-slot digital-out block. Each of NGPIO output channels gets a DEPTH-entry timed event queue, so the host can pipeline several schedule_digital_out edges per pin.
- Fire comparison is wrap-safe ("due or late") instead of exact-equality.
- Sits on the command dispatcher bus: arg stream in, one status word back per schedule command.

---
 rtl/gpio_sched_pkg.sv | 32 +++
 rtl/gpio_sched_queue.sv | 86 ++++++++
 rtl/gpio_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gpio_sched_pkg.sv
// Shared types for gpio_sched: FSM states, status codes, queue entry and wrap-safe due test.
// Pure declarations, no logic or latency of its own.
package gpio_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CFG_VAL,
      S_CFG_DEF,
      S_CFG_DUR,
      S_SCH_TIME,
      S_SCH_VAL,
      S_SET_VAL
   } state_t;

   localparam logic [31:0] ST_OK       = 32'd0;
   localparam logic [31:0] ST_FULL     = 32'd1;
   localparam logic [31:0] ST_SHUTDOWN = 32'd2;
   localparam logic [31:0] ST_BADCH    = 32'd3;

   typedef struct packed {
      logic [31:0] tstamp;
      logic        value;
   } entry_t;

   // Due or late: the signed distance from t to systime is non-negative.
   function automatic logic time_due(input logic [31:0] systime, input logic [31:0] t);
      logic [31:0] diff;
      diff = systime - t;
      return ~diff[31];
   endfunction

endpackage

// File: rtl/gpio_sched_queue.sv
// One channel: DEPTH-entry timed event FIFO, head fire test, duration timeout, default/max_duration.
// fire/expire are combinational from registered state; a full queue refuses pushes unless the head pops.
module gpio_sched_queue
   import gpio_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] systime_i,
   input  logic        push_i,
   input  entry_t      push_entry_i,
   input  logic        flush_i,
   input  logic        shutdown_i,
   input  logic        def_wr_i,
   input  logic        def_value_i,
   input  logic        maxdur_wr_i,
   input  logic [31:0] maxdur_i,
   output logic        fire_o,
   output logic        fire_value_o,
   output logic        expire_o,
   output logic        full_o,
   output logic        default_value_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   entry_t      mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0] dur_q, dur_d, maxdur_q;
   logic        def_q;
   logic        empty, pop, push_ok;
   entry_t      head;

   // Extra wrap bit distinguishes full from empty, so all DEPTH slots are usable.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign pop     = !empty && !shutdown_i && time_due(systime_i, head.tstamp);
   assign push_ok = push_i && !flush_i && !shutdown_i && (!full_o || pop);

   assign fire_o          = pop;
   assign fire_value_o    = head.value;
   assign expire_o        = !shutdown_i && !pop && (dur_q == 32'd1);
   assign default_value_o = def_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i || shutdown_i) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
   end

   always_comb begin
      dur_d = dur_q;
      if (shutdown_i)        dur_d = '0;
      else if (pop)          dur_d = maxdur_q;
      else if (dur_q != '0)  dur_d = dur_q - 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dur_q    <= '0;
         maxdur_q <= '0;
         def_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dur_q    <= dur_d;
         if (maxdur_wr_i) maxdur_q <= maxdur_i;
         if (def_wr_i)    def_q    <= def_value_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
   end

endmodule

// File: rtl/gpio_sched.sv
// Command-driven digital-out scheduler: NGPIO channels, each with a timed event queue.
// One argument per clock; cmd_done/param_write are registered and pulse the cycle after the last argument.
module gpio_sched
   import gpio_sched_pkg::*;
#(
   parameter int                  NGPIO                    = 9,
   parameter int                  DEPTH                    = 4,
   parameter int                  CMD_BITS                 = 8,
   parameter logic [CMD_BITS-1:0] CMD_SET_DIGITAL_OUT      = CMD_BITS'(1),
   parameter logic [CMD_BITS-1:0] CMD_CONFIG_DIGITAL_OUT   = CMD_BITS'(2),
   parameter logic [CMD_BITS-1:0] CMD_SCHEDULE_DIGITAL_OUT = CMD_BITS'(3),
   parameter logic [CMD_BITS-1:0] CMD_UPDATE_DIGITAL_OUT   = CMD_BITS'(4),
   parameter logic [CMD_BITS-1:0] CMD_FLUSH_DIGITAL_OUT    = CMD_BITS'(5),
   parameter logic                RESET_LEVEL              = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         systime,
   input  logic [31:0]         arg_data,
   output logic                arg_advance,
   input  logic [CMD_BITS-1:0] cmd,
   input  logic                cmd_ready,
   output logic                cmd_done,
   output logic [31:0]         param_data,
   output logic                param_write,
   output logic [NGPIO-1:0]    gpio,
   output logic [NGPIO-1:0]    overflow,
   input  logic                shutdown
);

   localparam int CHW = (NGPIO > 1) ? $clog2(NGPIO) : 1;

   state_t           state_q, state_d;
   logic [CHW-1:0]   ch_q, ch_d;
   logic [31:0]      time_q, time_d;
   logic             cmd_done_q, done_d;
   logic             param_write_q, pw_d;
   logic [31:0]      param_data_q, pdata_d;
   logic [NGPIO-1:0] gpio_q, gpio_d, overflow_q;

   logic             gpio_wr, def_wr, dur_wr, cfg_flush, cmd_flush, push_en, ovf_set;
   logic [NGPIO-1:0] ch_sel, arg_sel;
   logic [NGPIO-1:0] fire_vec, fire_val_vec, expire_vec, full_vec, def_vec;

   assign arg_advance = 1'b1;
   assign cmd_done    = cmd_done_q;
   assign param_write = param_write_q;
   assign param_data  = param_data_q;
   assign gpio        = gpio_q;
   assign overflow    = overflow_q;

   // Out-of-range channel indices select nothing, so their writes vanish.
   always_comb begin
      ch_sel  = '0;
      arg_sel = '0;
      for (int i = 0; i < NGPIO; i++) begin
         ch_sel[i]  = (ch_q == CHW'(i));
         arg_sel[i] = (arg_data[CHW-1:0] == CHW'(i));
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      time_d    = time_q;
      done_d    = 1'b0;
      pw_d      = 1'b0;
      pdata_d   = param_data_q;
      gpio_wr   = 1'b0;
      def_wr    = 1'b0;
      dur_wr    = 1'b0;
      cfg_flush = 1'b0;
      cmd_flush = 1'b0;
      push_en   = 1'b0;
      ovf_set   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_ready) begin
               ch_d = arg_data[CHW-1:0];
               if (cmd == CMD_CONFIG_DIGITAL_OUT) begin
                  state_d = S_CFG_VAL;
               end else if (cmd == CMD_SCHEDULE_DIGITAL_OUT) begin
                  state_d = S_SCH_TIME;
               end else if (cmd == CMD_SET_DIGITAL_OUT || cmd == CMD_UPDATE_DIGITAL_OUT) begin
                  state_d = S_SET_VAL;
               end else begin
                  done_d    = 1'b1;
                  cmd_flush = (cmd == CMD_FLUSH_DIGITAL_OUT);
               end
            end
         end
         S_CFG_VAL: begin
            gpio_wr = 1'b1;
            state_d = S_CFG_DEF;
         end
         S_CFG_DEF: begin
            def_wr  = 1'b1;
            state_d = S_CFG_DUR;
         end
         S_CFG_DUR: begin
            dur_wr    = 1'b1;
            cfg_flush = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         S_SCH_TIME: begin
            time_d  = arg_data;
            state_d = S_SCH_VAL;
         end
         S_SCH_VAL: begin
            done_d  = 1'b1;
            pw_d    = 1'b1;
            state_d = S_IDLE;
            if (ch_sel == '0) begin
               pdata_d = ST_BADCH;
            end else if (shutdown) begin
               pdata_d = ST_SHUTDOWN;
            end else if (|(full_vec & ~fire_vec & ch_sel)) begin
               pdata_d = ST_FULL;
               ovf_set = 1'b1;
            end else begin
               pdata_d = ST_OK;
               push_en = 1'b1;
            end
         end
         S_SET_VAL: begin
            gpio_wr = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   for (genvar g = 0; g < NGPIO; g++) begin : g_ch
      gpio_sched_queue #(.DEPTH(DEPTH)) u_queue (
         .clk_i           (clk),
         .rst_i           (rst),
         .systime_i       (systime),
         .push_i          (push_en && ch_sel[g]),
         .push_entry_i    ({time_q, arg_data[0]}),
         .flush_i         ((cfg_flush && ch_sel[g]) || (cmd_flush && arg_sel[g])),
         .shutdown_i      (shutdown),
         .def_wr_i        (def_wr && ch_sel[g]),
         .def_value_i     (arg_data[0]),
         .maxdur_wr_i     (dur_wr && ch_sel[g]),
         .maxdur_i        (arg_data),
         .fire_o          (fire_vec[g]),
         .fire_value_o    (fire_val_vec[g]),
         .expire_o        (expire_vec[g]),
         .full_o          (full_vec[g]),
         .default_value_o (def_vec[g])
      );
   end

   // Per-pin priority: shutdown, then fire, then timeout, then host write.
   always_comb begin
      gpio_d = gpio_q;
      for (int i = 0; i < NGPIO; i++) begin
         if (shutdown)                  gpio_d[i] = def_vec[i];
         else if (fire_vec[i])          gpio_d[i] = fire_val_vec[i];
         else if (expire_vec[i])        gpio_d[i] = def_vec[i];
         else if (gpio_wr && ch_sel[i]) gpio_d[i] = arg_data[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         ch_q          <= '0;
         time_q        <= '0;
         cmd_done_q    <= 1'b0;
         param_write_q <= 1'b0;
         param_data_q  <= '0;
         gpio_q        <= {NGPIO{RESET_LEVEL}};
         overflow_q    <= '0;
      end else begin
         state_q       <= state_d;
         ch_q          <= ch_d;
         time_q        <= time_d;
         cmd_done_q    <= done_d;
         param_write_q <= pw_d;
         param_data_q  <= pdata_d;
         gpio_q        <= gpio_d;
         overflow_q    <= overflow_q | (ovf_set ? ch_sel : '0);
      end
   end

endmodule
